// File: rtl/sbox_inv_search.sv
// Inverse search over the 4-bit forward S-box: scans all candidates through a
// combinational copy of the forward map and reports the smallest preimage and the preimage count.
module sbox_inv_search #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic       resp_found,
  output logic [4:0] resp_count
);

  localparam int DATA_W = 4;
  localparam int CNT_W  = DATA_W + 1;
  localparam logic [DATA_W-1:0] CAND_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(1 << DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] first;
  logic [CNT_W-1:0]  count;
  logic              found;
  logic              match;

  // Must stay bit-exact with the forward substitution network.
  function automatic logic [DATA_W-1:0] sbox_fwd(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    case (x)
      4'h0:    y = 4'hF;
      4'h1:    y = 4'h3;
      4'h2:    y = 4'h2;
      4'h3:    y = 4'hF;
      4'h4:    y = 4'h6;
      4'h5:    y = 4'hA;
      4'h6:    y = 4'hD;
      4'h7:    y = 4'h2;
      4'h8:    y = 4'h5;
      4'h9:    y = 4'h8;
      4'hA:    y = 4'hC;
      4'hB:    y = 4'h1;
      4'hC:    y = 4'hC;
      4'hD:    y = 4'h9;
      4'hE:    y = 4'h3;
      default: y = 4'h4;
    endcase
    return y;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  assign match = (sbox_fwd(cand) == target);

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if ((EARLY_EXIT && match) || (cand == CAND_LAST)) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Search state: target latched at accept, one candidate evaluated per SCAN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      target <= '0;
      count  <= '0;
      found  <= 1'b0;
      first  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target <= req_data;
            cand   <= '0;
            count  <= '0;
            found  <= 1'b0;
            first  <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            count <= sat_inc(count);
            if (!found) begin
              first <= cand;
              found <= 1'b1;
            end
          end
          if (cand != CAND_LAST) cand <= cand + DATA_W'(1);
        end
        default: ;
      endcase
    end
  end

  // first stays 0 unless a match was recorded, so it doubles as the no-hit value.
  assign resp_data  = found ? first : '0;
  assign resp_found = found;
  assign resp_count = count;

endmodule

// File: tb/tb_sbox_inv_search.sv
// Directed bench for sbox_inv_search; one instance per EARLY_EXIT setting.
module tb_sbox_inv_search;

  logic       clk;
  logic       rst;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic [3:0] req_data   [2];
  logic       resp_valid [2];
  logic       resp_ready [2];
  logic [3:0] resp_data  [2];
  logic       resp_found [2];
  logic [4:0] resp_count [2];

  int checks = 0;
  int errors = 0;

  // Preimage tables derived by hand from f = F,3,2,F,6,A,D,2,5,8,C,1,C,9,3,4.
  logic [3:0] exp_first [16] = '{4'h0, 4'hB, 4'h2, 4'h1, 4'hF, 4'h8, 4'h4, 4'h0,
                                 4'h9, 4'hD, 4'h5, 4'h0, 4'hA, 4'h6, 4'h0, 4'h0};
  logic [4:0] exp_count [16] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd0,
                                 5'd1, 5'd1, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd2};

  sbox_inv_search #(.EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_data(req_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
    .resp_found(resp_found[0]), .resp_count(resp_count[0])
  );

  sbox_inv_search #(.EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_data(req_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
    .resp_found(resp_found[1]), .resp_count(resp_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input int sel, input logic [3:0] t, input int exp_lat,
                         input logic [3:0] ed, input logic ef, input logic [4:0] ec,
                         input string tag);
    int lat;
    chk({tag, ".req_ready"}, 32'(req_ready[sel]), 32'd1);
    req_valid[sel] = 1'b1;
    req_data[sel]  = t;
    tick();
    req_valid[sel] = 1'b0;
    req_data[sel]  = ~t;
    lat = 0;
    while (!resp_valid[sel] && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"},  32'(resp_data[sel]),  32'(ed));
    chk({tag, ".found"}, 32'(resp_found[sel]), 32'(ef));
    chk({tag, ".count"}, 32'(resp_count[sel]), 32'(ec));
    tick();
    chk({tag, ".idle_valid"}, 32'(resp_valid[sel]), 32'd0);
    chk({tag, ".idle_ready"}, 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    logic [3:0] none_tgts [4];
    int lat;
    int stray;
    none_tgts = '{4'h7, 4'h0, 4'hB, 4'hE};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      req_data[s]   = 4'h0;
      resp_ready[s] = 1'b1;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      chk("reset.req_ready",  32'(req_ready[s]),  32'd1);
      chk("reset.resp_valid", 32'(resp_valid[s]), 32'd0);
      chk("reset.resp_data",  32'(resp_data[s]),  32'd0);
      chk("reset.resp_found", 32'(resp_found[s]), 32'd0);
      chk("reset.resp_count", 32'(resp_count[s]), 32'd0);
    end

    // Full scan: two preimages, then a single preimage
    run_req(0, 4'hF, 16, 4'h0, 1'b1, 5'd2, "full_F");
    run_req(0, 4'h6, 16, 4'h4, 1'b1, 5'd1, "full_6");

    // Targets with no preimage
    for (int i = 0; i < 4; i++)
      run_req(0, none_tgts[i], 16, 4'h0, 1'b0, 5'd0, "nohit");

    // Back-pressure with a pending request held on the input
    resp_ready[0] = 1'b0;
    req_valid[0]  = 1'b1;
    req_data[0]   = 4'hC;
    tick();
    req_data[0] = 4'h2;
    lat = 0;
    while (!resp_valid[0] && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd16);
    chk("bp.data",  32'(resp_data[0]),  32'hA);
    chk("bp.count", 32'(resp_count[0]), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", 32'(resp_valid[0]), 32'd1);
      chk("bp.hold_data",  32'(resp_data[0]),  32'hA);
      chk("bp.hold_count", 32'(resp_count[0]), 32'd2);
      chk("bp.hold_ready", 32'(req_ready[0]),  32'd0);
    end
    resp_ready[0] = 1'b1;
    tick();
    chk("bp.after_hs_valid", 32'(resp_valid[0]), 32'd0);
    chk("bp.after_hs_ready", 32'(req_ready[0]),  32'd1);
    tick();
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp2.latency", 32'(lat), 32'd16);
    chk("bp2.data",  32'(resp_data[0]),  32'h2);
    chk("bp2.count", 32'(resp_count[0]), 32'd2);
    tick();

    // Reset in the middle of a scan aborts it
    req_valid[0] = 1'b1;
    req_data[0]  = 4'h3;
    tick();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.req_ready",  32'(req_ready[0]),  32'd1);
    chk("abort.resp_valid", 32'(resp_valid[0]), 32'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid[0]) stray++;
      tick();
    end
    chk("abort.no_resp", 32'(stray), 32'd0);
    run_req(0, 4'h8, 16, 4'h9, 1'b1, 5'd1, "post_abort_8");

    // Early exit: last-candidate hit and first-candidate hit
    run_req(1, 4'h4, 16, 4'hF, 1'b1, 5'd1, "ee_4");
    run_req(1, 4'hF, 1,  4'h0, 1'b1, 5'd1, "ee_F");

    // Sweep all targets on both variants
    for (int t = 0; t < 16; t++) begin
      run_req(0, 4'(t), 16, exp_first[t], (exp_count[t] != 0), exp_count[t], "sweep_full");
      run_req(1, 4'(t), (exp_count[t] != 0) ? int'(exp_first[t]) + 1 : 16,
              exp_first[t], (exp_count[t] != 0), (exp_count[t] != 0) ? 5'd1 : 5'd0,
              "sweep_ee");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
